// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the peek FIFO family.
// Imported by the interface, register file and FIFO top.
package fifo_pkg;

  localparam int DEFAULT_DEPTH_BITS = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/peek_fifo_param_if.sv
// Request/response bundle between a FIFO user and the FIFO core.
// The user side is the master; the FIFO is the slave.
interface peek_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS
);
  logic                  clear;
  logic                  push;
  logic [WIDTH-1:0]      data_in;
  logic                  pop;
  logic [DEPTH_BITS-1:0] peek;
  logic [WIDTH-1:0]      data_out;
  logic                  peek_valid;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [DEPTH_BITS:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, push, data_in, pop, peek,
    input  data_out, peek_valid, empty, full,
    input  almost_full, count, overflow, underflow
  );

  modport slave (
    input  clear, push, data_in, pop, peek,
    output data_out, peek_valid, empty, full,
    output almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_regfile.sv
// Flop array storage: one write port, one async read port.
// Contents are deliberately not reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write the addressed entry when enabled
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/peek_fifo_param.sv
// Parametrised FIFO with peek window, flags and sticky errors.
// Pointers, occupancy, flags and the registered peek output.
module peek_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
  parameter int AF_THRESH  = 12
) (
  input logic              clk,
  input logic              reset_n,
  peek_fifo_param_if.slave bus
);

  localparam int DB = DEPTH_BITS;
  localparam int N  = 1 << DB;
  localparam logic [DB:0]   CAP     = N[DB:0];
  localparam logic [DB:0]   AF      = AF_THRESH[DB:0];
  localparam logic [DB:0]   CNT_ONE = 1;
  localparam logic [DB-1:0] PTR_ONE = 1;

  logic [DB-1:0]    rd_ptr;
  logic [DB-1:0]    wr_ptr;
  logic [DB:0]      cnt;
  logic             ovf;
  logic             unf;
  logic [WIDTH-1:0] dout;
  logic             pv;

  logic             pop_ok;
  logic             push_ok;
  logic             pv_next;
  logic             we;
  logic [DB-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  // acceptance and peek lookup from pre-edge state
  always_comb begin
    pop_ok  = bus.pop & (cnt != '0);
    push_ok = bus.push & ((cnt != CAP) | pop_ok);
    we      = push_ok & reset_n & ~bus.clear;
    raddr   = rd_ptr + bus.peek;
    pv_next = {1'b0, bus.peek} < cnt;
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (N)
  ) u_rf (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  // pointers, occupancy, sticky errors and output register
  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      dout   <= '0;
      pv     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)      cnt <= cnt + CNT_ONE;
      else if (pop_ok && !push_ok) cnt <= cnt - CNT_ONE;
      if (bus.push && !push_ok) ovf <= 1'b1;
      if (bus.pop && !pop_ok)   unf <= 1'b1;
      pv   <= pv_next;
      dout <= pv_next ? rdata : '0;
    end
  end

  assign bus.data_out    = dout;
  assign bus.peek_valid  = pv;
  assign bus.count       = cnt;
  assign bus.empty       = (cnt == '0);
  assign bus.full        = (cnt == CAP);
  assign bus.almost_full = (cnt >= AF);
  assign bus.overflow    = ovf;
  assign bus.underflow   = unf;

endmodule

// File: tb/tb_peek_fifo_param.sv
// Bench for peek_fifo_param: directed plan plus random traffic.
// Expected values come from a queue-based model.
module tb_peek_fifo_param;

  localparam int W  = 8;
  localparam int DB = 4;
  localparam int N  = 16;
  localparam int AF = 12;

  logic clk;
  logic reset_n;

  peek_fifo_param_if #(.WIDTH(W), .DEPTH_BITS(DB)) bus ();

  peek_fifo_param #(
    .WIDTH      (W),
    .DEPTH_BITS (DB),
    .AF_THRESH  (AF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  logic [W-1:0] q[$];
  bit           m_ovf;
  bit           m_unf;
  logic [W-1:0] m_dout;
  bit           m_pv;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  int'(bus.data_out),    int'(m_dout));
    chk({tag, ".pv"},    int'(bus.peek_valid),  int'(m_pv));
    chk({tag, ".count"}, int'(bus.count),       q.size());
    chk({tag, ".empty"}, int'(bus.empty),       int'(q.size() == 0));
    chk({tag, ".full"},  int'(bus.full),        int'(q.size() == N));
    chk({tag, ".af"},    int'(bus.almost_full), int'(q.size() >= AF));
    chk({tag, ".ovf"},   int'(bus.overflow),    int'(m_ovf));
    chk({tag, ".unf"},   int'(bus.underflow),   int'(m_unf));
  endtask

  task automatic step(input string tag, input bit rst, input bit clr,
                      input bit ps, input logic [W-1:0] din,
                      input bit pp, input int pk);
    bit pop_ok;
    bit push_ok;
    @(negedge clk);
    reset_n     = ~rst;
    bus.clear   = clr;
    bus.push    = ps;
    bus.data_in = din;
    bus.pop     = pp;
    bus.peek    = DB'(pk);
    @(posedge clk);
    if (rst || clr) begin
      q.delete();
      m_ovf  = 0;
      m_unf  = 0;
      m_dout = '0;
      m_pv   = 0;
    end else begin
      m_pv   = pk < q.size();
      m_dout = m_pv ? q[pk] : '0;
      pop_ok  = pp && q.size() > 0;
      push_ok = ps && (q.size() < N || pop_ok);
      if (pp && !pop_ok) m_unf = 1;
      if (ps && !push_ok) m_ovf = 1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(din);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.clear = 0; bus.push = 0; bus.pop = 0;
    bus.data_in = '0; bus.peek = '0;
    m_ovf = 0; m_unf = 0; m_dout = '0; m_pv = 0;

    // 1: reset, three pushes, peek window
    step("rst", 1, 0, 0, 8'h00, 0, 0);
    chk("rst.count", int'(bus.count), 0);
    chk("rst.empty", int'(bus.empty), 1);
    step("t1p", 0, 0, 1, 8'h11, 0, 0);
    step("t1p", 0, 0, 1, 8'h22, 0, 0);
    step("t1p", 0, 0, 1, 8'h33, 0, 0);
    step("t1k0", 0, 0, 0, 8'h00, 0, 0);
    chk("t1.head", int'(bus.data_out), 'h11);
    step("t1k2", 0, 0, 0, 8'h00, 0, 2);
    chk("t1.peek2", int'(bus.data_out), 'h33);
    step("t1k3", 0, 0, 0, 8'h00, 0, 3);
    chk("t1.peek3pv", int'(bus.peek_valid), 0);

    // 2: fill to full, then overflow
    step("rst2", 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < N; i++) step("t2fill", 0, 0, 1, W'(i), 0, 0);
    chk("t2.full", int'(bus.full), 1);
    step("t2ovf", 0, 0, 1, 8'hEE, 0, 0);
    chk("t2.ovf", int'(bus.overflow), 1);
    step("t2head", 0, 0, 0, 8'h00, 0, 0);
    chk("t2.head", int'(bus.data_out), 'h00);

    // 3: full with push+pop, then drain
    step("t3pp", 0, 0, 1, 8'hAA, 1, 0);
    chk("t3.count", int'(bus.count), N);
    for (int i = 0; i < N - 1; i++) step("t3pop", 0, 0, 0, 8'h00, 1, 0);
    step("t3last", 0, 0, 0, 8'h00, 1, 0);
    chk("t3.lastval", int'(bus.data_out), 'hAA);
    chk("t3.empty", int'(bus.empty), 1);

    // 4: empty with push+pop
    step("rst4", 1, 0, 0, 8'h00, 0, 0);
    step("t4pp", 0, 0, 1, 8'h5C, 1, 0);
    chk("t4.unf", int'(bus.underflow), 1);
    step("t4k0", 0, 0, 0, 8'h00, 0, 0);
    chk("t4.head", int'(bus.data_out), 'h5C);

    // 5: wrap with paired push/pop
    step("rst5", 1, 0, 0, 8'h00, 0, 0);
    step("t5p", 0, 0, 1, 8'h00, 0, 0);
    for (int i = 1; i <= 40; i++) step("t5pp", 0, 0, 1, W'(i), 1, 0);

    // 6: clear mid-operation, reset with push held
    step("rst6", 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < N + 1; i++) step("t6fill", 0, 0, 1, W'(8'h40 + i), 0, 0);
    for (int i = 0; i < 9; i++) step("t6pop", 0, 0, 0, 8'h00, 1, 1);
    chk("t6.cnt7", int'(bus.count), 7);
    step("t6clr", 0, 1, 0, 8'h00, 0, 0);
    chk("t6.clrovf", int'(bus.overflow), 0);
    step("t6pre", 0, 0, 1, 8'h77, 0, 0);
    step("t6rst", 1, 0, 1, 8'h88, 0, 0);
    chk("t6.rstcnt", int'(bus.count), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 99) < 55), W'($urandom), ($urandom_range(0, 99) < 45),
           int'($urandom_range(0, N - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
